fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the ARM7TDMI-class core: successor to the

---
 rtl/gba_core_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/fetch_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_core_pkg.sv
// Shared core constants and the fetch-queue entry payload.
package gba_core_pkg;

  localparam logic [4:0] MODE_USER   = 5'b10000;
  localparam logic [4:0] MODE_FIQ    = 5'b10001;
  localparam logic [4:0] MODE_IRQ    = 5'b10010;
  localparam logic [4:0] MODE_SVC    = 5'b10011;
  localparam logic [4:0] MODE_ABORT  = 5'b10111;
  localparam logic [4:0] MODE_UNDEF  = 5'b11011;
  localparam logic [4:0] MODE_SYSTEM = 5'b11111;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;

  localparam logic [31:0] ARM_STEP   = 32'd4;
  localparam logic [31:0] THUMB_STEP = 32'd2;

  typedef enum logic {
    FQ_IDLE  = 1'b0,
    FQ_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        abort;
    logic        thumb;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Little-endian halfword pick from a 32-bit bus, zero-extended.
  function automatic logic [31:0] thumb_select(input logic [31:0] d, input logic a1);
    return a1 ? {16'h0000, d[31:16]} : {16'h0000, d[15:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; a pop frees its slot for a push in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: drives opcode reads, buffers tagged fetches,
// and presents the queue head to decode through a valid/ready handshake.
module fetch_prefetch_queue
  import gba_core_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        flush_thumb,
  input  logic        nWAIT,
  input  logic [31:0] D,
  input  logic        abort,
  output logic [31:0] A,
  output logic        nMREQ,
  output logic        seq,
  output logic [1:0]  mas,
  output logic        nOPC,
  output logic        nRW,
  output logic        tbit,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_thumb,
  output logic        instr_abort,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic         seq_q, seq_d;
  logic         tbit_q, tbit_d;

  logic             fifo_push, fifo_pop, fifo_clear;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     wr_entry, head;
  logic [31:0]      step;
  logic             full_after;

  sync_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (mclk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Entry captured from the bus on a completing transfer.
  always_comb begin
    wr_entry.abort = abort;
    wr_entry.thumb = tbit_q;
    wr_entry.pc    = addr_q;
    wr_entry.instr = tbit_q ? thumb_select(D, addr_q[1]) : D;
  end

  assign fifo_pop = instr_valid && instr_ready;
  assign step     = tbit_q ? THUMB_STEP : ARM_STEP;
  // Queue would have no room for another fetch once this one lands.
  assign full_after = fifo_pop ? fifo_full : (fifo_count >= CNT_W'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    seq_d      = seq_q;
    tbit_d     = tbit_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
    if (flush) begin
      fifo_clear = 1'b1;
      state_d    = FQ_FETCH;
      addr_d     = flush_target & (flush_thumb ? ~32'h1 : ~32'h3);
      seq_d      = 1'b0;
      tbit_d     = flush_thumb;
    end else begin
      case (state_q)
        FQ_IDLE: begin
          if (!fifo_full || fifo_pop) begin
            state_d = FQ_FETCH;
            seq_d   = 1'b0;
          end
        end
        FQ_FETCH: begin
          if (nWAIT) begin
            fifo_push = 1'b1;
            addr_d    = addr_q + step;
            seq_d     = 1'b1;
            if (full_after) begin
              state_d = FQ_IDLE;
              seq_d   = 1'b0;
            end
          end
        end
        default: state_d = FQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= FQ_IDLE;
      addr_q  <= RESET_VECTOR;
      seq_q   <= 1'b0;
      tbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seq_q   <= seq_d;
      tbit_q  <= tbit_d;
    end
  end

  assign A           = addr_q;
  assign nMREQ       = (state_q != FQ_FETCH);
  assign nOPC        = (state_q != FQ_FETCH);
  assign nRW         = 1'b0;
  assign seq         = seq_q;
  assign mas         = tbit_q ? MAS_HALF : MAS_WORD;
  assign tbit        = tbit_q;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_thumb = head.thumb;
  assign instr_abort = head.abort;
  assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a memory model and an
// in-order scoreboard of expected queue entries.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        mclk = 1'b0;
  logic        reset, flush, flush_thumb, nWAIT, abort, instr_ready;
  logic [31:0] flush_target, D;
  logic [31:0] A, instr, instr_pc;
  logic        nMREQ, seq, nOPC, nRW, tbit, instr_thumb, instr_abort, instr_valid;
  logic [1:0]  mas;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_VECTOR(RV)) dut (
    .mclk         (mclk),
    .reset        (reset),
    .flush        (flush),
    .flush_target (flush_target),
    .flush_thumb  (flush_thumb),
    .nWAIT        (nWAIT),
    .D            (D),
    .abort        (abort),
    .A            (A),
    .nMREQ        (nMREQ),
    .seq          (seq),
    .mas          (mas),
    .nOPC         (nOPC),
    .nRW          (nRW),
    .tbit         (tbit),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_thumb  (instr_thumb),
    .instr_abort  (instr_abort),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        thumb;
    logic        abort;
  } sb_ent_t;

  sb_ent_t     sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          completions = 0;
  int          prev_kind  = 0;   // 0 idle/flush/reset, 1 completed, 2 waited
  logic        last_seq   = 1'b0;
  logic [31:0] exp_a      = RV;
  logic        exp_thumb  = 1'b0;
  logic        abort_en   = 1'b0;
  logic [31:0] abort_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:3] == 29'h20) return 32'hBEEF_CAFE;
    return {a[15:0] ^ 16'hA5A5, a[15:0] ^ 16'h3C3C};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive memory response, check bus and head, update the model.
  task automatic step();
    sb_ent_t e;
    logic    exp_seq;
    D     = mem_word(exp_a);
    abort = abort_en && (exp_a == abort_addr);
    if (reset) begin
      sb.delete();
      exp_a     = RV;
      exp_thumb = 1'b0;
      prev_kind = 0;
    end else begin
      if (!nMREQ) begin
        exp_seq = (prev_kind == 1) ? 1'b1 : ((prev_kind == 2) ? last_seq : 1'b0);
        chk("A", A, exp_a);
        chk("seq", 32'(seq), 32'(exp_seq));
        chk("mas", 32'(mas), exp_thumb ? 32'd1 : 32'd2);
        chk("tbit", 32'(tbit), 32'(exp_thumb));
        chk("nOPC", 32'(nOPC), 32'd0);
        chk("nRW", 32'(nRW), 32'd0);
        last_seq = exp_seq;
      end
      chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
      if (instr_valid && instr_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("head_instr", instr, e.instr);
        chk("head_pc", instr_pc, e.pc);
        chk("head_thumb", 32'(instr_thumb), 32'(e.thumb));
        chk("head_abort", 32'(instr_abort), 32'(e.abort));
      end
      if (flush) begin
        sb.delete();
        exp_thumb = flush_thumb;
        exp_a     = flush_target & (flush_thumb ? ~32'h1 : ~32'h3);
        prev_kind = 0;
      end else if (!nMREQ && nWAIT) begin
        e.instr = exp_thumb ? (exp_a[1] ? {16'h0, D[31:16]} : {16'h0, D[15:0]}) : D;
        e.pc    = exp_a;
        e.thumb = exp_thumb;
        e.abort = abort;
        sb.push_back(e);
        exp_a     = exp_a + (exp_thumb ? 32'd2 : 32'd4);
        prev_kind = 1;
        completions++;
      end else if (!nMREQ) begin
        prev_kind = 2;
      end else begin
        prev_kind = 0;
      end
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] tgt, input logic th);
    flush = 1'b1; flush_target = tgt; flush_thumb = th;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int start;
    int cyc;
    reset = 1'b1; flush = 1'b0; flush_target = 32'h0; flush_thumb = 1'b0;
    nWAIT = 1'b1; D = 32'h0; abort = 1'b0; instr_ready = 1'b1;
    step(); step();
    chk("rst_A", A, RV);
    chk("rst_nMREQ", 32'(nMREQ), 32'd1);
    chk("rst_nOPC", 32'(nOPC), 32'd1);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_mas", 32'(mas), 32'd2);
    chk("rst_tbit", 32'(tbit), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_thumb_abort", 32'({instr_thumb, instr_abort}), 32'd0);
    reset = 1'b0;

    // ARM streaming from the reset vector
    start = completions; cyc = 0;
    while (completions - start < 6 && cyc < 20) begin step(); cyc++; end
    chk("t1_completions", 32'(completions - start), 32'd6);

    // wait states hold the request
    do_flush(32'h8, 1'b0);
    nWAIT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_A", A, 32'h8);
      chk("t3_seq", 32'(seq), 32'd0);
      chk("t3_nMREQ", 32'(nMREQ), 32'd0);
      step();
      chk("t3_nopush", 32'(instr_valid), 32'd0);
    end
    nWAIT = 1'b1;
    chk("t3_A_final", A, 32'h8);
    step();
    chk("t3_valid", 32'(instr_valid), 32'd1);
    chk("t3_pc", instr_pc, 32'h8);
    chk("t3_instr", instr, 32'hA5AD_3C34);

    // back-pressure fills the queue, then resumes non-sequential
    instr_ready = 1'b0;
    do_flush(32'h20, 1'b0);
    start = completions;
    repeat (10) step();
    chk("t2_completions", 32'(completions - start), 32'd4);
    chk("t2_idle", 32'(nMREQ), 32'd1);
    chk("t2_head_pc", instr_pc, 32'h20);
    instr_ready = 1'b1;
    cyc = 0;
    while (nMREQ !== 1'b0 && cyc < 8) begin step(); cyc++; end
    chk("t2_resume_req", 32'(nMREQ), 32'd0);
    chk("t2_resume_A", A, 32'h30);
    chk("t2_resume_seq", 32'(seq), 32'd0);

    // Thumb flush while a transfer is stalled
    nWAIT = 1'b0;
    step();
    do_flush(32'h103, 1'b1);
    nWAIT = 1'b1;
    chk("t4_A", A, 32'h102);
    chk("t4_seq", 32'(seq), 32'd0);
    chk("t4_mas", 32'(mas), 32'd1);
    chk("t4_nMREQ", 32'(nMREQ), 32'd0);
    step();
    chk("t4_instr", instr, 32'h0000_BEEF);
    chk("t4_thumb", 32'(instr_thumb), 32'd1);
    chk("t4_A2", A, 32'h104);
    chk("t4_seq2", 32'(seq), 32'd1);
    step();
    chk("t4_instr2", instr, 32'h0000_CAFE);
    chk("t4_pc2", instr_pc, 32'h104);

    // reset in the middle of a stalled Thumb transfer
    nWAIT = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst2_nMREQ", 32'(nMREQ), 32'd1);
    chk("rst2_A", A, RV);
    chk("rst2_tbit", 32'(tbit), 32'd0);
    chk("rst2_mas", 32'(mas), 32'd2);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0; nWAIT = 1'b1;
    repeat (3) step();

    // flush coincident with a completing transfer
    instr_ready = 1'b0;
    do_flush(32'h40, 1'b0);
    step(); step();
    chk("t5_pre_valid", 32'(instr_valid), 32'd1);
    chk("t5_req", 32'(nMREQ), 32'd0);
    do_flush(32'h200, 1'b0);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_A", A, 32'h200);
    instr_ready = 1'b1;
    step();
    chk("t5_pc", instr_pc, 32'h200);

    // prefetch abort tagging
    abort_en = 1'b1; abort_addr = 32'h10;
    do_flush(32'h10, 1'b0);
    step();
    chk("t6_abort", 32'(instr_abort), 32'd1);
    chk("t6_pc", instr_pc, 32'h10);
    step();
    chk("t6_abort2", 32'(instr_abort), 32'd0);
    chk("t6_pc2", instr_pc, 32'h14);
    abort_en = 1'b0;

    // address wrap at the top of memory
    do_flush(32'hFFFF_FFFE, 1'b0);
    chk("wrap_A0", A, 32'hFFFF_FFFC);
    step();
    chk("wrap_A1", A, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
